// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory address and
// loads the IF/ID register, honouring stalls, branch redirects and HALT.
module if_stage #(
    parameter int                ADDR_W   = 8,
    parameter int                INSTR_W  = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [ADDR_W-1:0]  ifid_pc,
    output logic               ifid_valid,
    output logic               halted
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [4:0] OP_HALT = 5'b00001;

    state_t             state, state_n;
    logic [ADDR_W-1:0]  pc, pc_n;
    logic [INSTR_W-1:0] instr_n;
    logic [ADDR_W-1:0]  ifid_pc_n;
    logic               valid_n;
    logic               halted_n;

    assign imem_addr = pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            ifid_instr <= '0;
            ifid_pc    <= '0;
            ifid_valid <= 1'b0;
            halted     <= 1'b0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            ifid_instr <= instr_n;
            ifid_pc    <= ifid_pc_n;
            ifid_valid <= valid_n;
            halted     <= halted_n;
        end
    end

    always_comb begin
        state_n   = state;
        pc_n      = pc;
        instr_n   = ifid_instr;
        ifid_pc_n = ifid_pc;
        valid_n   = ifid_valid;

        case (state)
            IDLE: begin
                instr_n = '0;
                valid_n = 1'b0;
                if (enable) state_n = RUN;
            end
            RUN: begin
                // Redirect outranks stall: a resolved branch must never be held off.
                if (branch_taken) begin
                    pc_n    = branch_target;
                    instr_n = '0;
                    valid_n = 1'b0;
                end else if (!stall) begin
                    instr_n   = imem_rdata;
                    ifid_pc_n = pc;
                    valid_n   = 1'b1;
                    if (imem_rdata[INSTR_W-1 -: 5] == OP_HALT) state_n = HALT;
                    else                                       pc_n    = pc + 1'b1;
                end
            end
            HALT: begin
                instr_n = '0;
                valid_n = 1'b0;
                if (branch_taken) begin
                    pc_n    = branch_target;
                    state_n = RUN;
                end
            end
            default: state_n = IDLE;
        endcase

        halted_n = (state_n == HALT);
    end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: behavioural fetch model checked every cycle, plus directed
// literal checks of sequential fetch, stall, branch, HALT, PC wrap and async reset.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [7:0]  branch_target = '0;

    logic [7:0]  imem_addr;
    logic [15:0] imem_rdata;
    logic [15:0] ifid_instr;
    logic [7:0]  ifid_pc;
    logic        ifid_valid;
    logic        halted;

    logic [7:0]  fe_addr;
    logic [15:0] fe_rdata;
    logic [15:0] fe_instr;
    logic [7:0]  fe_pc;
    logic        fe_valid;
    logic        fe_halted;

    logic [15:0] mem [256];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign imem_rdata = mem[imem_addr];
    assign fe_rdata   = mem[fe_addr];

    if_stage #(.ADDR_W(8), .INSTR_W(16), .RESET_PC(8'h00)) u_dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
        .ifid_instr(ifid_instr), .ifid_pc(ifid_pc), .ifid_valid(ifid_valid),
        .halted(halted)
    );

    if_stage #(.ADDR_W(8), .INSTR_W(16), .RESET_PC(8'hFE)) u_dut_fe (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .imem_addr(fe_addr), .imem_rdata(fe_rdata),
        .stall(1'b0), .branch_taken(1'b0), .branch_target(8'h00),
        .ifid_instr(fe_instr), .ifid_pc(fe_pc), .ifid_valid(fe_valid),
        .halted(fe_halted)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: 0 = waiting for enable, 1 = fetching, 2 = halted.
    int          m_mode;
    logic [7:0]  m_pc;
    logic [15:0] m_instr;
    logic [7:0]  m_pcq;
    logic        m_valid;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode <= 0; m_pc <= 8'h00; m_instr <= 16'h0000; m_pcq <= 8'h00; m_valid <= 1'b0;
        end else if (m_mode == 0) begin
            if (enable) m_mode <= 1;
        end else if (m_mode == 1) begin
            if (branch_taken) begin
                m_pc <= branch_target; m_instr <= 16'h0000; m_valid <= 1'b0;
            end else if (!stall) begin
                m_instr <= mem[m_pc]; m_pcq <= m_pc; m_valid <= 1'b1;
                if (mem[m_pc][15:11] == 5'd1) m_mode <= 2;
                else                          m_pc <= m_pc + 8'd1;
            end
        end else begin
            m_instr <= 16'h0000; m_valid <= 1'b0;
            if (branch_taken) begin
                m_pc <= branch_target; m_mode <= 1;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            chk("model_addr",   {24'd0, imem_addr},  {24'd0, m_pc});
            chk("model_instr",  {16'd0, ifid_instr}, {16'd0, m_instr});
            chk("model_pc",     {24'd0, ifid_pc},    {24'd0, m_pcq});
            chk("model_valid",  {31'd0, ifid_valid}, {31'd0, m_valid});
            chk("model_halted", {31'd0, halted},     {31'd0, (m_mode == 2)});
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic expect_if(input string name, input logic [15:0] ins, input logic [7:0] pc,
                             input logic v, input logic [7:0] addr, input logic h);
        chk({name, "_instr"},  {16'd0, ifid_instr}, {16'd0, ins});
        chk({name, "_pc"},     {24'd0, ifid_pc},    {24'd0, pc});
        chk({name, "_valid"},  {31'd0, ifid_valid}, {31'd0, v});
        chk({name, "_addr"},   {24'd0, imem_addr},  {24'd0, addr});
        chk({name, "_halted"}, {31'd0, halted},     {31'd0, h});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
        mem[7] = 16'h0800;

        step(); step();
        expect_if("reset", 16'h0000, 8'h00, 1'b0, 8'h00, 1'b0);
        chk("reset_fe_addr", {24'd0, fe_addr}, 32'hFE);
        rst_n = 1'b1;

        step();
        expect_if("idle_noen", 16'h0000, 8'h00, 1'b0, 8'h00, 1'b0);
        enable = 1'b1;
        step();
        enable = 1'b0;
        expect_if("enable_edge", 16'h0000, 8'h00, 1'b0, 8'h00, 1'b0);

        step();
        expect_if("seq0", 16'h1000, 8'h00, 1'b1, 8'h01, 1'b0);
        chk("wrap0_pc", {24'd0, fe_pc}, 32'hFE);
        chk("wrap0_instr", {16'd0, fe_instr}, 32'h10FE);
        step();
        expect_if("seq1", 16'h1001, 8'h01, 1'b1, 8'h02, 1'b0);
        chk("wrap1_pc", {24'd0, fe_pc}, 32'hFF);
        step();
        expect_if("seq2", 16'h1002, 8'h02, 1'b1, 8'h03, 1'b0);
        chk("wrap2_pc", {24'd0, fe_pc}, 32'h00);
        chk("wrap2_instr", {16'd0, fe_instr}, 32'h1000);
        step();
        expect_if("seq3", 16'h1003, 8'h03, 1'b1, 8'h04, 1'b0);
        chk("wrap3_pc", {24'd0, fe_pc}, 32'h01);

        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            expect_if("stall", 16'h1003, 8'h03, 1'b1, 8'h04, 1'b0);
        end
        stall = 1'b0;
        step();
        expect_if("post_stall", 16'h1004, 8'h04, 1'b1, 8'h05, 1'b0);
        step();
        expect_if("seq5", 16'h1005, 8'h05, 1'b1, 8'h06, 1'b0);

        branch_taken = 1'b1; branch_target = 8'h40; stall = 1'b1;
        step();
        branch_taken = 1'b0; stall = 1'b0;
        expect_if("branch_flush", 16'h0000, 8'h05, 1'b0, 8'h40, 1'b0);
        step();
        expect_if("branch_tgt", 16'h1040, 8'h40, 1'b1, 8'h41, 1'b0);

        branch_taken = 1'b1; branch_target = 8'h07;
        step();
        branch_taken = 1'b0;
        expect_if("to_halt_flush", 16'h0000, 8'h40, 1'b0, 8'h07, 1'b0);
        step();
        expect_if("halt_cap", 16'h0800, 8'h07, 1'b1, 8'h07, 1'b1);
        step();
        expect_if("halt_bubble", 16'h0000, 8'h07, 1'b0, 8'h07, 1'b1);
        stall = 1'b1;
        step();
        expect_if("halt_stall", 16'h0000, 8'h07, 1'b0, 8'h07, 1'b1);
        stall = 1'b0;
        branch_taken = 1'b1; branch_target = 8'h01;
        step();
        branch_taken = 1'b0;
        expect_if("halt_exit", 16'h0000, 8'h07, 1'b0, 8'h01, 1'b0);
        step();
        expect_if("halt_resume", 16'h1001, 8'h01, 1'b1, 8'h02, 1'b0);

        #3;
        rst_n = 1'b0;
        #1;
        expect_if("async_reset", 16'h0000, 8'h00, 1'b0, 8'h00, 1'b0);
        chk("async_reset_fe_addr", {24'd0, fe_addr}, 32'hFE);
        #1;
        rst_n = 1'b1;
        step();
        expect_if("reidle0", 16'h0000, 8'h00, 1'b0, 8'h00, 1'b0);
        step();
        expect_if("reidle1", 16'h0000, 8'h00, 1'b0, 8'h00, 1'b0);
        enable = 1'b1;
        step();
        enable = 1'b0;
        step();
        expect_if("restart", 16'h1000, 8'h00, 1'b1, 8'h01, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the 16-bit pipelined CPU. It owns the program counter, drives the address of the combinational-read instruction memory, and captures the returned word into the IF/ID pipeline register for the decode stage. It applies hazard stalls and branch/jump redirects from downstream. It detects the HALT opcode, stops fetching after a HALT, and reports the halted state.

## Interface
- ADDR_W, 8, PC and instruction-memory address width
- INSTR_W, 16, instruction width; opcode is bits [INSTR_W-1 -: 5]
- RESET_PC, 8'h00, PC value after reset
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- enable  in  1  start fetching; sampled only in IDLE
- imem_addr  out  ADDR_W  instruction-memory address, equal to current PC
- imem_rdata  in  INSTR_W  instruction word, combinational from imem_addr in the same cycle
- stall  in  1  hazard hold from decode/hazard unit
- branch_taken  in  1  redirect request from a resolved branch/jump
- branch_target  in  ADDR_W  redirect address, valid while branch_taken=1
- ifid_instr  out  INSTR_W  IF/ID instruction register
- ifid_pc  out  ADDR_W  address the ifid_instr word was fetched from
- ifid_valid  out  1  ifid_instr holds a real fetched instruction; 0 means bubble (NOP)
- halted  out  1  high while in HALT state

## Operation
- Reset (rst_n=0, takes effect immediately):
  - pc=RESET_PC, state=IDLE.
  - ifid_instr=16'h0000 (NOP), ifid_pc=0, ifid_valid=0, halted=0.
- imem_addr = pc at all times, combinationally.
- States are IDLE, RUN and HALT, stored in a 2-bit register.
- IDLE:
  - pc is held and IF/ID holds the NOP bubble.
  - enable=1 moves to RUN at the next edge; nothing is captured on that edge.
- RUN: each rising edge applies the first matching rule, in this priority order:
  1. branch_taken=1: pc<=branch_target; ifid_instr<=NOP, ifid_valid<=0 (flush). stall is ignored.
  2. stall=1: pc, ifid_instr, ifid_pc and ifid_valid all hold.
  3. imem_rdata opcode == 5'b00001 (HALT): ifid_instr<=imem_rdata, ifid_pc<=pc, ifid_valid<=1. pc holds. State<=HALT.
  4. Otherwise: ifid_instr<=imem_rdata, ifid_pc<=pc, ifid_valid<=1, pc<=pc+1.
- PC arithmetic is modulo 2^ADDR_W: 8'hFF+1 = 8'h00, with no flag and no stop.
- HALT:
  - halted=1 and pc is frozen.
  - On every edge: ifid_instr<=NOP, ifid_valid<=0.
  - branch_taken=1 (an older branch resolving after a HALT fetched in its shadow): pc<=branch_target, IF/ID flushed, state<=RUN, halted drops on that edge.
  - stall has no effect in HALT.
  - Otherwise HALT is left only via rst_n.
- enable is ignored outside IDLE.
- Deasserting rst_n in any state returns the block to the reset values immediately.

## Timing
- Fetch latency is one edge: the word at address A appears on ifid_instr at the edge that ends the RUN cycle in which pc==A.
- Sustained throughput is one instruction per cycle with no stall or branch.
- Branch penalty is one bubble from this stage. The target word is in IF/ID one edge after the redirect edge.
- Stall is level-sensitive. N stall cycles hold IF/ID for N edges; fetch resumes on the first edge with stall=0.
- halted rises on the edge that captures HALT into IF/ID. The HALT word stays valid in IF/ID for exactly one cycle, then bubbles follow.
- All outputs are registered, except imem_addr, which is a combinational copy of pc.

## Test plan
- Sequential fetch: reset, enable=1 for one cycle, memory word at n = 16'h1000+n.
  - Expect IF/ID to show 1000,1001,1002… with ifid_pc 0,1,2… on consecutive edges; ifid_valid=1 from the second edge after enable.
- Stall: assert stall for 3 cycles while pc=4.
  - Expect imem_addr to stay 4 and ifid_instr/ifid_pc (word 3) to hold for 3 edges.
  - Next edge captures word 4.
- Branch with simultaneous stall: branch_taken=1, target=8'h40, stall=1 at pc=6.
  - Expect ifid_valid=0 and pc=8'h40 next edge.
  - Then ifid_instr=word 0x40 with ifid_pc=8'h40.
- HALT: HALT word (16'h0800) at address 7.
  - Expect IF/ID=16'h0800, ifid_pc=7, valid=1, halted=1 on the same edge.
  - Expect pc stuck at 7 and ifid_valid=0 on every later edge.
- Branch out of HALT: in HALT, pulse branch_taken with target=8'h01.
  - Expect halted=0, pc=1 and a flushed IF/ID.
  - Then word 1 fetched.
- Wrap and reset:
  - Run from RESET_PC=8'hFE: expect ifid_pc FE, FF, 00, 01.
  - Drop rst_n mid-cycle: expect all outputs at reset values before the next clk edge, and state IDLE until enable.
